fetch_unit: RTL and testbench

//   Instruction fetch stage; sits directly upstream of the instruction memory (port 1).

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// PC increment, and the {pc, instr} entry layout held in the fetch queue.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int          PC_STEP   = 4;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   // One fetch queue entry at the default widths, pc in the upper half
   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] pc;
      logic [DEF_DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

   // Width of a packed {pc, instr} entry for arbitrary address/data widths
   function automatic int entryWidth(input int addrWidth, input int dataWidth);
      return addrWidth + dataWidth;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// flush empties the queue and overrides push/pop on the same edge.
// dout shows the head entry; when empty it keeps the last head shown (0 after reset).
module fetch_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] held_q;
   logic             notEmpty;
   logic             doPush;
   logic             doPop;

   assign notEmpty = (count_q != '0);
   assign doPop    = pop & ~flush & notEmpty;
   assign doPush   = push & ~flush & ((count_q != CNT_W'(DEPTH)) | doPop);

   // Next pointer and occupancy; a flush returns everything to empty
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   // Pointer, occupancy and held-head registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         held_q  <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         if (notEmpty) held_q <= mem_q[rdPtr_q];
      end
   end

   // Storage array; contents are only ever read through a valid pointer
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= din;
   end

   assign dout  = notEmpty ? mem_q[rdPtr_q] : held_q;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the word-aligned fetch address to
// instruction memory, queues {pc, instr} pairs for decode and handles redirects.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0] instr,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  misalign_err
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   localparam int ENTRY_W = entryWidth(ADDR_WIDTH, DATA_WIDTH);
   localparam int CNT_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
   localparam logic [ADDR_WIDTH-1:0] START_PC = RESET_PC & ~ADDR_WIDTH'(3);

   logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
   logic                  misalign_q;
   logic [CNT_W-1:0]      fifoCount;
   logic [ENTRY_W-1:0]    fifoDin;
   logic [ENTRY_W-1:0]    fifoDout;
   logic                  fifoFull;
   logic                  pop;
   logic                  push;

   assign fifoFull = (fifoCount == CNT_W'(FIFO_DEPTH));
   assign if_valid = (fifoCount != '0);
   assign pop      = if_valid & if_ready;
   assign push     = ~redirect_valid & (~fifoFull | pop);
   assign fifoDin  = {fetchPc_q, instr};

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (fifoDin),
      .dout  (fifoDout),
      .count (fifoCount)
   );

   assign if_pc    = fifoDout[ENTRY_W-1:DATA_WIDTH];
   assign if_instr = fifoDout[DATA_WIDTH-1:0];

   // Next PC: a redirect wins, otherwise advance one word whenever a fetch is queued
   always_comb begin
      fetchPc_d = fetchPc_q;
      if (redirect_valid) begin
         fetchPc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (push) begin
         fetchPc_d = fetchPc_q + ADDR_WIDTH'(PC_STEP);
      end
   end

   // PC register and the one-cycle misaligned-redirect flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchPc_q  <= START_PC;
         misalign_q <= 1'b0;
      end else begin
         fetchPc_q  <= fetchPc_d;
         misalign_q <= redirect_valid & (|redirect_pc[1:0]);
      end
   end

   assign instr_addr   = fetchPc_q;
   assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
   logic [31:0] perfFetch_q;
   logic [31:0] perfStall_q;

   // Free-running counters of queued fetches and cycles stalled on a full queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perfFetch_q <= '0;
         perfStall_q <= '0;
      end else begin
         if (push)             perfFetch_q <= perfFetch_q + 32'd1;
         if (fifoFull & ~pop)  perfStall_q <= perfStall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perfFetch_q;
   assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// ready/redirect traffic, compared against a queue-based behavioural model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instrAddr, instr;
   logic        ifValid, ifReady;
   logic [31:0] ifPc, ifInstr;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        misalignErr;

   logic [31:0] wrapAddr, wrapInstr;
   logic        wrapValid;
   logic [31:0] wrapPc, wrapIfInstr;
   logic        wrapMis;

`ifdef FETCH_PERF_EN
   logic [31:0] perfFetch, perfStall;
   logic [31:0] wrapPerfFetch, wrapPerfStall;
`endif

   logic [31:0] memArr [64];

   // Behavioural model state
   logic [31:0]  mPc;
   fetch_entry_t mQ[$];
   logic [31:0]  mLastPc, mLastInstr;
   logic         mMis;
   int unsigned  mFetchCnt, mStallCnt;

   int checks = 0;
   int errors = 0;

   // Clock generation
   always #5 clk = ~clk;

   // Combinational instruction memory: low 256 bytes populated, NOP elsewhere
   assign instr     = (instrAddr < 32'd256) ? memArr[instrAddr[7:2]] : NOP_INSTR;
   assign wrapInstr = (wrapAddr  < 32'd256) ? memArr[wrapAddr[7:2]]  : NOP_INSTR;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_addr     (instrAddr),
      .instr          (instr),
      .if_valid       (ifValid),
      .if_ready       (ifReady),
      .if_pc          (ifPc),
      .if_instr       (ifInstr),
      .redirect_valid (redirectValid),
      .redirect_pc    (redirectPc),
      .misalign_err   (misalignErr)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perfFetch),
      .perf_stall_cnt (perfStall)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFFFFFC), .FIFO_DEPTH(DEPTH)) dutWrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_addr     (wrapAddr),
      .instr          (wrapInstr),
      .if_valid       (wrapValid),
      .if_ready       (1'b1),
      .if_pc          (wrapPc),
      .if_instr       (wrapIfInstr),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .misalign_err   (wrapMis)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (wrapPerfFetch),
      .perf_stall_cnt (wrapPerfStall)
`endif
   );

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (a < 32'd256) return memArr[a[7:2]];
      return NOP_INSTR;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel(input logic [31:0] startPc);
      mPc        = startPc;
      mQ.delete();
      mLastPc    = '0;
      mLastInstr = '0;
      mMis       = 1'b0;
      mFetchCnt  = 0;
      mStallCnt  = 0;
   endtask

   // Compare every main-DUT output with the model, then note the head shown
   task automatic checkAll(input string phase);
      logic        expValid;
      logic [31:0] expPc, expInstr;
      expValid = (mQ.size() != 0);
      expPc    = expValid ? mQ[0].pc    : mLastPc;
      expInstr = expValid ? mQ[0].instr : mLastInstr;
      checkOutput({phase, "/if_valid"},   32'(ifValid),     32'(expValid));
      checkOutput({phase, "/instr_addr"}, instrAddr,        mPc);
      checkOutput({phase, "/if_pc"},      ifPc,             expPc);
      checkOutput({phase, "/if_instr"},   ifInstr,          expInstr);
      checkOutput({phase, "/misalign"},   32'(misalignErr), 32'(mMis));
`ifdef FETCH_PERF_EN
      checkOutput({phase, "/perf_fetch"}, perfFetch,        mFetchCnt);
      checkOutput({phase, "/perf_stall"}, perfStall,        mStallCnt);
`endif
      if (expValid) begin
         mLastPc    = expPc;
         mLastInstr = expInstr;
      end
   endtask

   // Drive one cycle of inputs, advance the model, and step to the next sample point
   task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
      bit pop, canPush;
      ifReady       = ready;
      redirectValid = rv;
      redirectPc    = rpc;
      pop = (mQ.size() != 0) && ready;
      if (mQ.size() == DEPTH && !pop) mStallCnt++;
      if (rv) begin
         mQ.delete();
         mPc  = {rpc[31:2], 2'b00};
         mMis = |rpc[1:0];
      end else begin
         mMis    = 1'b0;
         canPush = (mQ.size() < DEPTH) || pop;
         if (pop) void'(mQ.pop_front());
         if (canPush) begin
            mQ.push_back('{pc: mPc, instr: memRead(mPc)});
            mPc = mPc + 32'd4;
            mFetchCnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) memArr[i] = $urandom;
      memArr[0] = 32'h00500093;
      memArr[1] = 32'h00100113;

      rst_n         = 1'b0;
      ifReady       = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = '0;
      resetModel(32'h0);
      repeat (2) @(negedge clk);

      // Reset state
      checkAll("reset");
      checkOutput("reset/wrap_addr", wrapAddr, 32'hFFFFFFFC);
      checkOutput("reset/wrap_valid", 32'(wrapValid), 32'h0);

      // First fetches after release, plus PC wrap on the second instance
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("t1c1");
      checkOutput("t1/pc0", ifPc, 32'h0);
      checkOutput("t1/instr0", ifInstr, 32'h00500093);
      checkOutput("wrap/pc0", wrapPc, 32'hFFFFFFFC);
      checkOutput("wrap/valid0", 32'(wrapValid), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("t1c2");
      checkOutput("t1/pc4", ifPc, 32'h4);
      checkOutput("t1/instr4", ifInstr, 32'h00100113);
      checkOutput("wrap/pc1", wrapPc, 32'h0);
      checkOutput("wrap/instr1", wrapIfInstr, 32'h00500093);

      // Stall, then reset asynchronously while full
      repeat (5) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkAll("stall");
      end
      #2 rst_n = 1'b0;
      #1;
      resetModel(32'h0);
      checkOutput("rstmid/if_valid", 32'(ifValid), 32'h0);
      checkOutput("rstmid/instr_addr", instrAddr, 32'h0);
`ifdef FETCH_PERF_EN
      checkOutput("rstmid/perf_fetch", perfFetch, 32'h0);
      checkOutput("rstmid/perf_stall", perfStall, 32'h0);
`endif
      @(negedge clk);
      checkAll("rstmid");
      rst_n = 1'b1;

      // Decode stall from reset: queue saturates, PC holds at 8, then drains in order
      repeat (5) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkAll("t2stall");
      end
      checkOutput("t2/addr_hold", instrAddr, 32'h8);
      checkOutput("t2/head", ifPc, 32'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkAll("t2drain");
         checkOutput("t2/seq", ifPc, 32'(4 * (k + 1)));
      end

      // Redirect while full, misaligned redirect, back-to-back redirects
      repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("t3fill");
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkAll("t3redir");
      checkOutput("t3/valid", 32'(ifValid), 32'h0);
      checkOutput("t3/addr", instrAddr, 32'h40);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("t3target");
      checkOutput("t3/pc", ifPc, 32'h40);
      applyStimulus(1'b1, 1'b1, 32'h43);
      checkAll("t4redir");
      checkOutput("t4/addr", instrAddr, 32'h40);
      checkOutput("t4/mis", 32'(misalignErr), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("t4after");
      checkOutput("t4/mis_clear", 32'(misalignErr), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h80);
      applyStimulus(1'b1, 1'b1, 32'h20);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("b2b");
      checkOutput("b2b/pc", ifPc, 32'h20);

      // Random ready/redirect traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic        rdy, rv;
         logic [31:0] tgt;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 9) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 300));
         applyStimulus(rdy, rv, tgt);
         checkAll("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
